// File: rtl/response_router_pkg.sv
// Shared definitions for the response router: PSL response codes, the sticky
// error vector layout, and the code-to-error classifier.
package response_router_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned ERR_W  = 10;

  // PSL response codes
  localparam logic [CODE_W-1:0] RC_DONE    = 8'h00;
  localparam logic [CODE_W-1:0] RC_AERROR  = 8'h01;
  localparam logic [CODE_W-1:0] RC_DERROR  = 8'h03;
  localparam logic [CODE_W-1:0] RC_FLUSHED = 8'h06;
  localparam logic [CODE_W-1:0] RC_FAULT   = 8'h07;
  localparam logic [CODE_W-1:0] RC_FAILED  = 8'h08;
  localparam logic [CODE_W-1:0] RC_PAGED   = 8'h0A;

  // Sticky error vector bit positions
  localparam int unsigned ERR_PARITY     = 0;
  localparam int unsigned ERR_RANGE      = 1;
  localparam int unsigned ERR_CREDIT_OVF = 2;
  localparam int unsigned ERR_CREDIT_UDF = 3;
  localparam int unsigned ERR_AERROR     = 4;
  localparam int unsigned ERR_DERROR     = 5;
  localparam int unsigned ERR_FAULT      = 6;
  localparam int unsigned ERR_FAILED     = 7;
  localparam int unsigned ERR_PAGED      = 8;
  localparam int unsigned ERR_FLUSHED    = 9;

  // Map a response code onto its error bit; DONE and unknown codes map to none.
  function automatic logic [ERR_W-1:0] code_to_err(input logic [CODE_W-1:0] code);
    logic [ERR_W-1:0] err;
    err = '0;
    case (code)
      RC_AERROR:  err[ERR_AERROR]  = 1'b1;
      RC_DERROR:  err[ERR_DERROR]  = 1'b1;
      RC_FAULT:   err[ERR_FAULT]   = 1'b1;
      RC_FAILED:  err[ERR_FAILED]  = 1'b1;
      RC_PAGED:   err[ERR_PAGED]   = 1'b1;
      RC_FLUSHED: err[ERR_FLUSHED] = 1'b1;
      default:    err = '0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/parity.sv
// Parity generator.
//   i_data     : data word
//   i_odd      : 1 = odd parity, 0 = even parity
//   o_parity_c : parity bit that makes data+parity match the selected sense
module parity #(
  parameter int unsigned BITS = 8
) (
  input  logic [BITS-1:0] i_data,
  input  logic            i_odd,
  output logic            o_parity_c
);

  assign o_parity_c = (^i_data) ^ i_odd;

endmodule

// File: rtl/response_credit_counter.sv
// Saturating command-credit counter.
//   clock, rstn      : clock, async active-low reset
//   i_en             : update enable (counter holds when low)
//   i_init_valid     : load i_init (clamped to MAX_CREDITS), overrides all else
//   i_init           : initial credit value
//   i_consume        : one command issued this cycle
//   i_return_valid   : i_return is a valid signed credit return
//   i_return         : signed credit return
//   o_credits        : current credits (registered)
//   o_overflow_c     : sum exceeded MAX_CREDITS this cycle
//   o_underflow_c    : sum went negative, or consume while empty, this cycle
module response_credit_counter #(
  parameter int unsigned CREDIT_WIDTH = 9,
  parameter int unsigned MAX_CREDITS  = 64
) (
  input  logic                          clock,
  input  logic                          rstn,
  input  logic                          i_en,
  input  logic                          i_init_valid,
  input  logic [$clog2(MAX_CREDITS):0]  i_init,
  input  logic                          i_consume,
  input  logic                          i_return_valid,
  input  logic [CREDIT_WIDTH-1:0]       i_return,
  output logic [$clog2(MAX_CREDITS):0]  o_credits,
  output logic                          o_overflow_c,
  output logic                          o_underflow_c
);

  localparam int unsigned CW = $clog2(MAX_CREDITS) + 1;
  // Two guard bits so the single-adder sum never wraps before saturation.
  localparam int unsigned SW = ((CW > CREDIT_WIDTH) ? CW : CREDIT_WIDTH) + 2;

  logic [CW-1:0]        r_credits;
  logic [CW-1:0]        w_next;
  logic signed [SW-1:0] w_cur;
  logic signed [SW-1:0] w_cons;
  logic signed [SW-1:0] w_ret;
  logic signed [SW-1:0] w_max;
  logic signed [SW-1:0] w_sum;

  // Next-credit computation with saturation flags
  always_comb begin
    w_next        = r_credits;
    o_overflow_c  = 1'b0;
    o_underflow_c = 1'b0;
    w_cur  = $signed({{(SW-CW){1'b0}}, r_credits});
    w_cons = $signed({{(SW-1){1'b0}}, i_consume});
    w_ret  = i_return_valid ? $signed({{(SW-CREDIT_WIDTH){i_return[CREDIT_WIDTH-1]}}, i_return})
                            : '0;
    w_max  = $signed(SW'(MAX_CREDITS));
    w_sum  = w_cur - w_cons + w_ret;
    if (i_en) begin
      if (i_init_valid) begin
        w_next = (i_init > CW'(MAX_CREDITS)) ? CW'(MAX_CREDITS) : i_init;
      end else begin
        if (w_sum > w_max) begin
          w_next       = CW'(MAX_CREDITS);
          o_overflow_c = 1'b1;
        end else if (w_sum[SW-1]) begin
          w_next        = '0;
          o_underflow_c = 1'b1;
        end else begin
          w_next = w_sum[CW-1:0];
        end
        // Issuing with no credit left is an underflow even if a return nets it out.
        if (i_consume && (r_credits == '0)) o_underflow_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) r_credits <= '0;
    else       r_credits <= w_next;
  end

  assign o_credits = r_credits;

endmodule

// File: rtl/response_router.sv
// PSL response router: joins each response with the tag-buffer channel index,
// routes a one-hot strobe to NUM_CHANNELS consumers (2-cycle latency), tracks
// command credits, checks tag parity and keeps a sticky error vector.
// Optional per-channel response counters: define RESPONSE_ROUTER_COUNTERS_EN.
//   clock, rstn              : clock, async active-low reset
//   enabled_in               : block enable (registered internally)
//   response_*_in            : PSL response strobe, tag, tag parity, code, credits
//   tag_channel_in           : channel for the tag currently in stage 0
//   credit_init_valid_in/_in : credit counter load
//   credit_consume_in        : one command issued this cycle
//   error_clear_in           : clear sticky errors
//   channel_valid_out        : one-hot routed strobe
//   response_tag/code_out    : routed tag and code
//   credits_available_out    : current credits
//   response_count_out       : per-channel counts, channel 0 in the LSBs
//   error_out                : sticky error vector
module response_router
  import response_router_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned CREDIT_WIDTH = 9,
  parameter int unsigned MAX_CREDITS  = 64,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                            clock,
  input  logic                            rstn,
  input  logic                            enabled_in,
  input  logic                            response_valid_in,
  input  logic [TAG_WIDTH-1:0]            response_tag_in,
  input  logic                            response_tag_parity_in,
  input  logic [7:0]                      response_code_in,
  input  logic [CREDIT_WIDTH-1:0]         response_credits_in,
  input  logic [$clog2(NUM_CHANNELS):0]   tag_channel_in,
  input  logic                            credit_init_valid_in,
  input  logic [$clog2(MAX_CREDITS):0]    credit_init_in,
  input  logic                            credit_consume_in,
  input  logic                            error_clear_in,
  output logic [NUM_CHANNELS-1:0]         channel_valid_out,
  output logic [TAG_WIDTH-1:0]            response_tag_out,
  output logic [7:0]                      response_code_out,
  output logic [$clog2(MAX_CREDITS):0]    credits_available_out,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] response_count_out,
  output logic [9:0]                      error_out
);

  localparam int unsigned CHW = $clog2(NUM_CHANNELS) + 1;

  logic                    r_enabled;
  logic                    r_parity_ref;
  logic                    r_s0_valid;
  logic [TAG_WIDTH-1:0]    r_s0_tag;
  logic                    r_s0_parity;
  logic [CODE_W-1:0]       r_s0_code;
  logic [CREDIT_WIDTH-1:0] r_s0_credits;
  logic [NUM_CHANNELS-1:0] r_s2_valid;
  logic [TAG_WIDTH-1:0]    r_s2_tag;
  logic [CODE_W-1:0]       r_s2_code;
  logic [ERR_W-1:0]        r_err;

  logic                    w_calc_parity;
  logic                    w_parity_err;
  logic                    w_range_err;
  logic [NUM_CHANNELS-1:0] w_onehot;
  logic [ERR_W-1:0]        w_code_err;
  logic [ERR_W-1:0]        w_new_err;
  logic                    w_credit_ovf;
  logic                    w_credit_udf;

  // Enable register and stage 0 capture
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_enabled    <= 1'b0;
      r_parity_ref <= 1'b1;
      r_s0_valid   <= 1'b0;
      r_s0_tag     <= '0;
      r_s0_parity  <= 1'b0;
      r_s0_code    <= '0;
      r_s0_credits <= '0;
    end else begin
      r_enabled <= enabled_in;
      if (r_enabled && response_valid_in) begin
        r_s0_valid   <= 1'b1;
        r_s0_tag     <= response_tag_in;
        r_s0_parity  <= response_tag_parity_in;
        r_s0_code    <= response_code_in;
        r_s0_credits <= response_credits_in;
      end else begin
        r_s0_valid   <= 1'b0;
        r_s0_tag     <= '0;
        r_s0_parity  <= 1'b0;
        r_s0_code    <= '0;
        r_s0_credits <= '0;
      end
    end
  end

  parity #(.BITS(TAG_WIDTH)) u_tag_parity (
    .i_data     (r_s0_tag),
    .i_odd      (r_parity_ref),
    .o_parity_c (w_calc_parity)
  );

  // Stage 1: channel decode, parity check, code classification
  always_comb begin
    w_onehot     = '0;
    w_range_err  = 1'b0;
    w_parity_err = 1'b0;
    w_code_err   = '0;
    if (r_s0_valid) begin
      w_parity_err = (w_calc_parity != r_s0_parity);
      w_code_err   = code_to_err(r_s0_code);
      if (tag_channel_in >= CHW'(NUM_CHANNELS)) begin
        w_range_err = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          w_onehot[i] = (tag_channel_in == CHW'(i));
        end
      end
    end
  end

  response_credit_counter #(
    .CREDIT_WIDTH (CREDIT_WIDTH),
    .MAX_CREDITS  (MAX_CREDITS)
  ) u_credits (
    .clock          (clock),
    .rstn           (rstn),
    .i_en           (r_enabled),
    .i_init_valid   (credit_init_valid_in),
    .i_init         (credit_init_in),
    .i_consume      (credit_consume_in),
    .i_return_valid (r_s0_valid),
    .i_return       (r_s0_credits),
    .o_credits      (credits_available_out),
    .o_overflow_c   (w_credit_ovf),
    .o_underflow_c  (w_credit_udf)
  );

  // Collect this cycle's newly detected errors
  always_comb begin
    w_new_err                 = w_code_err;
    w_new_err[ERR_PARITY]     = w_parity_err;
    w_new_err[ERR_RANGE]      = w_range_err;
    w_new_err[ERR_CREDIT_OVF] = w_credit_ovf;
    w_new_err[ERR_CREDIT_UDF] = w_credit_udf;
  end

  // Stage 2 output register and sticky errors (new error beats clear)
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_s2_valid <= '0;
      r_s2_tag   <= '0;
      r_s2_code  <= '0;
      r_err      <= '0;
    end else begin
      r_err <= (error_clear_in ? '0 : r_err) | w_new_err;
      if (r_enabled) begin
        r_s2_valid <= w_onehot;
        r_s2_tag   <= r_s0_tag;
        r_s2_code  <= r_s0_code;
      end else begin
        r_s2_valid <= '0;
        r_s2_tag   <= '0;
        r_s2_code  <= '0;
      end
    end
  end

  assign channel_valid_out = r_s2_valid;
  assign response_tag_out  = r_s2_tag;
  assign response_code_out = r_s2_code;
  assign error_out         = r_err;

`ifdef RESPONSE_ROUTER_COUNTERS_EN
  logic [CNT_WIDTH-1:0] r_cnt [NUM_CHANNELS];

  // Counts advance on the same edge that loads the strobe into stage 2.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) r_cnt[i] <= '0;
    end else if (r_enabled) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (w_onehot[i]) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    response_count_out = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      response_count_out[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt[i];
    end
  end
`else
  assign response_count_out = '0;
`endif

endmodule

// File: tb/tb_response_router.sv
// Scoreboard bench for response_router (NUM_CHANNELS=4 defaults).
module tb_response_router;

  localparam int unsigned NCH  = 4;
  localparam int unsigned TW   = 8;
  localparam int unsigned CRW  = 9;
  localparam int unsigned MAXC = 64;
  localparam int unsigned CNTW = 32;
  localparam int unsigned CHW  = $clog2(NCH) + 1;
  localparam int unsigned CW   = $clog2(MAXC) + 1;

  logic              clock = 1'b0;
  logic              rstn  = 1'b0;
  logic              enabled_in;
  logic              response_valid_in;
  logic [TW-1:0]     response_tag_in;
  logic              response_tag_parity_in;
  logic [7:0]        response_code_in;
  logic [CRW-1:0]    response_credits_in;
  logic [CHW-1:0]    tag_channel_in;
  logic              credit_init_valid_in;
  logic [CW-1:0]     credit_init_in;
  logic              credit_consume_in;
  logic              error_clear_in;
  logic [NCH-1:0]    channel_valid_out;
  logic [TW-1:0]     response_tag_out;
  logic [7:0]        response_code_out;
  logic [CW-1:0]     credits_available_out;
  logic [NCH*CNTW-1:0] response_count_out;
  logic [9:0]        error_out;

  response_router dut (
    .clock                  (clock),
    .rstn                   (rstn),
    .enabled_in             (enabled_in),
    .response_valid_in      (response_valid_in),
    .response_tag_in        (response_tag_in),
    .response_tag_parity_in (response_tag_parity_in),
    .response_code_in       (response_code_in),
    .response_credits_in    (response_credits_in),
    .tag_channel_in         (tag_channel_in),
    .credit_init_valid_in   (credit_init_valid_in),
    .credit_init_in         (credit_init_in),
    .credit_consume_in      (credit_consume_in),
    .error_clear_in         (error_clear_in),
    .channel_valid_out      (channel_valid_out),
    .response_tag_out       (response_tag_out),
    .response_code_out      (response_code_out),
    .credits_available_out  (credits_available_out),
    .response_count_out     (response_count_out),
    .error_out              (error_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int             due;
    logic [NCH-1:0] onehot;
    logic [TW-1:0]  tag;
    logic [7:0]     code;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_strobe_cyc = -1;
  logic        en_model;
  logic [CHW-1:0] chan_d;
  int unsigned exp_cnt[NCH];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Tag-buffer model: channel follows its tag into stage 0; mirror of enable register
  always @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      tag_channel_in <= '0;
      en_model       <= 1'b0;
    end else begin
      tag_channel_in <= chan_d;
      en_model       <= enabled_in;
    end
  end

  // Output monitor: pop the scoreboard when an entry is due, else expect silence
  always @(negedge clock) begin
    if (rstn) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("strobe", 64'(channel_valid_out), 64'(e.onehot));
        check("tag",    64'(response_tag_out),  64'(e.tag));
        check("code",   64'(response_code_out), 64'(e.code));
      end else if (channel_valid_out != '0) begin
        check("spurious_strobe", 64'(channel_valid_out), 64'(0));
      end
      if (channel_valid_out != '0) last_strobe_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [TW-1:0] tag, input logic [7:0] code,
                      input logic [CRW-1:0] cr, input int unsigned ch, input bit par_ok);
    exp_t e;
    response_valid_in      = 1'b1;
    response_tag_in        = tag;
    response_tag_parity_in = par_ok ? ~^tag : ^tag;
    response_code_in       = code;
    response_credits_in    = cr;
    chan_d                 = CHW'(ch);
    if (en_model && enabled_in && ch < NCH) begin
      e.due    = cyc + 2;
      e.onehot = NCH'(1) << ch;
      e.tag    = tag;
      e.code   = code;
      sb.push_back(e);
      exp_cnt[ch]++;
    end
    tick();
    response_valid_in   = 1'b0;
    response_tag_in     = '0;
    response_code_in    = '0;
    response_credits_in = '0;
    chan_d              = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_err();
    error_clear_in = 1'b1;
    tick();
    error_clear_in = 1'b0;
    check("err_cleared", 64'(error_out), 64'(0));
  endtask

  task automatic init_credits(input logic [CW-1:0] v);
    credit_init_valid_in = 1'b1;
    credit_init_in       = v;
    tick();
    credit_init_valid_in = 1'b0;
  endtask

  task automatic consume(input int n);
    credit_consume_in = 1'b1;
    idle(n);
    credit_consume_in = 1'b0;
  endtask

  task automatic check_counts(input string name);
    for (int i = 0; i < NCH; i++) begin
`ifdef RESPONSE_ROUTER_COUNTERS_EN
      check(name, 64'(response_count_out[i*CNTW +: CNTW]), 64'(exp_cnt[i]));
`else
      check(name, 64'(response_count_out[i*CNTW +: CNTW]), 64'(0));
`endif
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"},   64'(channel_valid_out),     64'(0));
    check({name, "_tag"},     64'(response_tag_out),      64'(0));
    check({name, "_code"},    64'(response_code_out),     64'(0));
    check({name, "_credits"}, 64'(credits_available_out), 64'(0));
    check({name, "_err"},     64'(error_out),             64'(0));
    check({name, "_count"},   64'(response_count_out),    64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] codes [9];
    logic [9:0] code_err [9];
    int drop_cyc;

    codes    = '{8'h01, 8'h03, 8'h07, 8'h08, 8'h0A, 8'h06, 8'h00, 8'h02, 8'hFF};
    code_err = '{10'h010, 10'h020, 10'h040, 10'h080, 10'h100, 10'h200, 10'h000, 10'h000, 10'h000};
    for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;

    enabled_in = 1'b0; response_valid_in = 1'b0; response_tag_in = '0;
    response_tag_parity_in = 1'b0; response_code_in = '0; response_credits_in = '0;
    credit_init_valid_in = 1'b0; credit_init_in = '0; credit_consume_in = 1'b0;
    error_clear_in = 1'b0; chan_d = '0;

    // Reset state
    idle(3);
    check_all_zero("reset");
    rstn = 1'b1;
    enabled_in = 1'b1;
    idle(2);

    // Basic routing
    send(8'h05, 8'h00, '0, 2, 1'b1);
    idle(3);
    check("basic_err", 64'(error_out), 64'(0));

    // Parity: good then bad, clear, clear coinciding with a new parity error
    send(8'h03, 8'h00, '0, 0, 1'b1);
    send(8'h03, 8'h00, '0, 1, 1'b0);
    idle(2);
    check("parity_err", 64'(error_out), 64'(1));
    clear_err();
    send(8'h03, 8'h00, '0, 3, 1'b0);
    error_clear_in = 1'b1;
    tick();
    error_clear_in = 1'b0;
    check("parity_vs_clear", 64'(error_out), 64'(1));
    idle(2);
    clear_err();

    // Credits: consume, net-zero return, saturation, negative return, init clamp
    init_credits(7'd64);
    check("credit_init", 64'(credits_available_out), 64'(64));
    consume(3);
    check("credit_consume3", 64'(credits_available_out), 64'(61));
    send(8'h10, 8'h00, 9'd1, 0, 1'b1);
    consume(1);
    check("credit_net_zero", 64'(credits_available_out), 64'(61));
    check("credit_net_err", 64'(error_out), 64'(0));
    send(8'h11, 8'h00, 9'd10, 0, 1'b1);
    idle(2);
    check("credit_sat", 64'(credits_available_out), 64'(64));
    check("credit_ovf_err", 64'(error_out), 64'(4));
    clear_err();
    send(8'h12, 8'h00, 9'h1FD, 1, 1'b1);
    idle(2);
    check("credit_neg_return", 64'(credits_available_out), 64'(61));
    init_credits(7'd100);
    check("credit_init_clamp", 64'(credits_available_out), 64'(64));

    // Underflow
    init_credits(7'd1);
    consume(2);
    check("credit_udf", 64'(credits_available_out), 64'(0));
    check("credit_udf_err", 64'(error_out), 64'(8));
    clear_err();

    // Channel range boundaries
    send(8'h22, 8'h00, '0, 5, 1'b1);
    idle(2);
    check("range_5", 64'(error_out), 64'(2));
    clear_err();
    send(8'h23, 8'h00, '0, 4, 1'b1);
    idle(2);
    check("range_4", 64'(error_out), 64'(2));
    clear_err();
    send(8'h24, 8'h00, '0, 3, 1'b1);
    idle(2);
    check("range_3", 64'(error_out), 64'(0));

    // Code classification
    for (int i = 0; i < 9; i++) begin
      send(8'h40 + 8'(i), codes[i], '0, i % NCH, 1'b1);
      idle(2);
      check($sformatf("code_%02h", codes[i]), 64'(error_out), 64'(code_err[i]));
      clear_err();
    end
    send(8'h30, 8'h01, '0, 3, 1'b1);
    send(8'h31, 8'h0A, '0, 3, 1'b1);
    idle(2);
    check("code_seq", 64'(error_out), 64'(10'h110));
    clear_err();

    // Burst to channel 1
    for (int i = 0; i < 10; i++) send(8'h50 + 8'(i), 8'h00, '0, 1, 1'b1);
    idle(3);
    check_counts("count_burst");

    // Enable drop mid-burst
    drop_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        enabled_in = 1'b0;
        drop_cyc   = cyc;
      end
      send(8'h70 + 8'(i), 8'h00, '0, 2, 1'b1);
    end
    idle(4);
    check("enable_drop_last", 64'(last_strobe_cyc), 64'(drop_cyc + 1));
    check("enable_drop_err", 64'(error_out), 64'(0));
    enabled_in = 1'b1;
    idle(2);
    check_counts("count_after_drop");

    // Reset mid-burst
    init_credits(7'd20);
    check("pre_reset_credits", 64'(credits_available_out), 64'(20));
    send(8'h61, 8'h00, '0, 0, 1'b0);
    idle(2);
    check("pre_reset_err", 64'(error_out), 64'(1));
    for (int i = 0; i < 4; i++) send(8'h62 + 8'(i), 8'h00, '0, 2, 1'b1);
    rstn = 1'b0;
    sb.delete();
    for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
    #1;
    check_all_zero("mid_reset");
    idle(2);
    rstn = 1'b1;
    idle(2);
    send(8'h7E, 8'h00, '0, 3, 1'b1);
    idle(3);
    check("post_reset_credits", 64'(credits_available_out), 64'(0));
    check("post_reset_err", 64'(error_out), 64'(0));
    check_counts("count_post_reset");

    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/response_router.md
Name: response_router

Overview:
- Parametrised successor of the single-stream response decoder.
- Takes PSL responses, joins each with the channel index returned by the external tag buffer, and routes a one-hot valid to one of NUM_CHANNELS consumers.
- Tracks command credits with saturation, checks tag parity, and classifies response codes into a sticky, clearable error vector.
- Sits between the PSL response interface and the per-engine (read/write/WED/restart/…) response handlers.

Parameters:
NUM_CHANNELS, 4, number of routed consumers (>=2)
TAG_WIDTH, 8, response tag width
CREDIT_WIDTH, 9, signed response credit field width
MAX_CREDITS, 64, credit counter ceiling
CNT_WIDTH, 32, per-channel response counter width

Ports:
clock  in  1  clock
rstn  in  1  asynchronous active-low reset
enabled_in  in  1  block enable; registered internally, one cycle of delay
response_valid_in  in  1  PSL response strobe
response_tag_in  in  TAG_WIDTH  response tag
response_tag_parity_in  in  1  odd parity over tag
response_code_in  in  8  PSL response code
response_credits_in  in  CREDIT_WIDTH  signed credit return
tag_channel_in  in  $clog2(NUM_CHANNELS)+1  channel for the stage-1 tag, from the tag buffer; combinational in the same cycle
credit_init_valid_in  in  1  load credit counter
credit_init_in  in  $clog2(MAX_CREDITS)+1  initial credits (ha_croom)
credit_consume_in  in  1  one command issued this cycle
error_clear_in  in  1  clear sticky errors
channel_valid_out  out  NUM_CHANNELS  one-hot routed response strobe
response_tag_out  out  TAG_WIDTH  routed tag
response_code_out  out  8  routed code
credits_available_out  out  $clog2(MAX_CREDITS)+1  current credits
response_count_out  out  NUM_CHANNELS*CNT_WIDTH  per-channel counts; channel 0 in the LSBs
error_out  out  10  sticky errors

Behaviour:
- Reset: every output and internal register goes to 0. The parity reference register resets to 1 (odd).
- enabled is enabled_in registered. When enabled=0:
  - pipeline stages load 0 and channel_valid_out=0;
  - credit, counter and error registers hold.
- Stage 0 (S0): registers tag, parity, code and credits when enabled && response_valid_in; otherwise registers 0.
- Stage 1 (S1): from the S0 contents plus tag_channel_in:
  - computes odd parity over the tag;
  - decodes tag_channel_in to one-hot;
  - out of range (>= NUM_CHANNELS) gives all-zero one-hot and raises the range error;
  - classifies the code.
- Stage 2 (S2): output register.
- Latency: response_valid_in in cycle N gives channel_valid_out in N+2. Full throughput, one response per cycle, no backpressure. Exactly one bit of channel_valid_out is set per valid in-range response.
- Credit counter, per cycle:
  - credit_init_valid_in overrides everything and loads credit_init_in, clamped to MAX_CREDITS.
  - Otherwise next = cur − credit_consume_in + (S0 valid ? sign-extended credits : 0), all in one adder, so consume and return in the same cycle net out.
  - Result > MAX_CREDITS saturates to MAX_CREDITS and sets err[2].
  - Result < 0 saturates to 0 and sets err[3].
  - credit_consume_in while the counter is 0 also sets err[3].
- Error bits, set at S1 and sticky:
  - err[0]: tag parity mismatch.
  - err[1]: channel out of range.
  - err[2]: credit overflow.
  - err[3]: credit underflow.
  - err[4]: AERROR, code 0x01.
  - err[5]: DERROR, code 0x03.
  - err[6]: FAULT, code 0x07.
  - err[7]: FAILED, code 0x08.
  - err[8]: PAGED, code 0x0A.
  - err[9]: FLUSHED, code 0x06.
- DONE (0x00) and all other codes raise no error.
- error_clear_in clears all bits. A new error detected in the same cycle as the clear wins (bit stays 1).
- Errors are still evaluated while enabled=0, but S0 is 0 then, so none arise.
- Reset mid-operation: in-flight responses are discarded with no output strobe, and credits return to 0.

Optional Feature:
- Macro: RESPONSE_ROUTER_COUNTERS_EN.
- Defined: each channel has a CNT_WIDTH counter incremented on its channel_valid_out bit. It wraps modulo 2^CNT_WIDTH and holds when disabled.
- Undefined: response_count_out is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package (CU_PKG):
  - response code constants;
  - error bit index localparams;
  - function mapping code to error bits.
- One sub-module: response_credit_counter (saturating signed credit arithmetic plus its overflow/underflow flags).
- Tag parity reuses the existing parity module with BITS=TAG_WIDTH.

Test Plan:
1. NUM_CHANNELS=4: valid, tag 0x05 with correct parity, code 0x00, tag_channel_in=2 → cycle+2 channel_valid_out=4'b0100, response_tag_out=0x05, error_out=0.
2. Parity check: tag 0x03 with parity 1 (correct is 1), then tag 0x03 with parity 0 → the second response sets err[0]; error_clear_in clears it; clear coinciding with a new parity error → bit stays 1.
3. Credits: init 64; 3 consume cycles (61); response with credits +1 plus consume in the same cycle (61); response credits +10 → 64 saturates and sets err[2].
4. Underflow: init 1; consume twice → credits 0, err[3]=1.
5. Range and codes: tag_channel_in=5 → no strobe, err[1]=1. Codes 0x01, 0x0A in sequence → err[4] and err[8] set.
6. Counters and reset: with RESPONSE_ROUTER_COUNTERS_EN, 10 responses to channel 1 → count[1]=10. Drop enabled_in mid-burst → strobes stop 2 cycles after enabled drops. Assert rstn low mid-burst → all outputs 0 immediately.
